// File: rtl/dctlb_l2req_sched.sv
// L1 data-TLB miss scheduler: merges and tracks up to four outstanding misses,
// issues them to the L2TLB round-robin, fills on ack and sequences displacement snoops.
module dctlb_l2req_sched #(
    parameter int VPN_W = 24,
    parameter int HPA_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss0_valid,
    output logic             miss0_retry,
    input  logic [VPN_W-1:0] miss0_vpn,
    input  logic             miss1_valid,
    output logic             miss1_retry,
    input  logic [VPN_W-1:0] miss1_vpn,
    input  logic             miss2_valid,
    output logic             miss2_retry,
    input  logic [VPN_W-1:0] miss2_vpn,
    output logic             l1tlbtol2tlb_req_valid,
    input  logic             l1tlbtol2tlb_req_retry,
    output logic [VPN_W-1:0] l1tlbtol2tlb_req_vpn,
    output logic [1:0]       l1tlbtol2tlb_req_id,
    input  logic             l2tlbtol1tlb_ack_valid,
    output logic             l2tlbtol1tlb_ack_retry,
    input  logic [1:0]       l2tlbtol1tlb_ack_id,
    input  logic [HPA_W-1:0] l2tlbtol1tlb_ack_hpaddr,
    output logic             fill_valid,
    output logic [VPN_W-1:0] fill_vpn,
    output logic [HPA_W-1:0] fill_hpaddr,
    input  logic             l2tlbtol1tlb_snoop_valid,
    output logic             l2tlbtol1tlb_snoop_retry,
    input  logic [HPA_W-1:0] l2tlbtol1tlb_snoop_hpaddr,
    output logic             inv_valid,
    input  logic             inv_retry,
    output logic [HPA_W-1:0] inv_hpaddr,
    output logic             l1tlbtol2tlb_sack_valid,
    input  logic             l1tlbtol2tlb_sack_retry,
    output logic [HPA_W-1:0] l1tlbtol2tlb_sack_hpaddr,
    output logic             err_ack,
    output logic [1:0]       dbg_snoop_state,
    output logic [7:0]       dbg_entry_state
);
    // Handshake: a transfer happens in any cycle where valid=1 and retry=0;
    // while retry=1 the sender holds valid and its payload unchanged.
    typedef enum logic [1:0] {E_IDLE = 2'd0, E_PEND = 2'd1, E_WAIT = 2'd2} ent_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_INV = 2'd1, S_SACK = 2'd2} snp_t;

    ent_t             ent_q [4];
    logic [VPN_W-1:0] vpn_q [4];
    logic [1:0]       rr_ptr;
    logic             req_valid_q;
    logic [VPN_W-1:0] req_vpn_q;
    logic [1:0]       req_id_q;
    logic             fill_valid_q;
    logic [VPN_W-1:0] fill_vpn_q;
    logic [HPA_W-1:0] fill_hpaddr_q;
    logic             err_ack_q;
    snp_t             snp_state, snp_next;
    logic [HPA_W-1:0] snp_hpaddr;

    logic [2:0]       idle_cnt;
    logic             alloc_found;
    logic [1:0]       alloc_id;
    logic [2:0]       match;
    logic [2:0]       acc;
    logic             do_alloc;
    logic [VPN_W-1:0] alloc_vpn;
    logic             can_load;
    logic             pick_found;
    logic [1:0]       pick_id;
    logic [1:0]       idx;

    // Free-entry count and merge detection use registered state only, so an
    // entry freed by an ack is not visible as IDLE until the following cycle.
    always_comb begin
        idle_cnt    = 3'd0;
        alloc_found = 1'b0;
        alloc_id    = 2'd0;
        match       = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (ent_q[i] == E_IDLE) begin
                idle_cnt = idle_cnt + 3'd1;
                if (!alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_id    = 2'(i);
                end
            end else begin
                if (vpn_q[i] == miss0_vpn) match[0] = 1'b1;
                if (vpn_q[i] == miss1_vpn) match[1] = 1'b1;
                if (vpn_q[i] == miss2_vpn) match[2] = 1'b1;
            end
        end
    end

    // Only the highest-priority valid miss is considered; prefetch keeps one entry spare.
    always_comb begin
        acc       = 3'b000;
        alloc_vpn = miss2_vpn;
        if (miss0_valid) begin
            acc[0]    = match[0] || (idle_cnt != 3'd0);
            alloc_vpn = miss0_vpn;
        end else if (miss1_valid) begin
            acc[1]    = match[1] || (idle_cnt != 3'd0);
            alloc_vpn = miss1_vpn;
        end else if (miss2_valid) begin
            acc[2]    = match[2] || (idle_cnt >= 3'd2);
        end
        do_alloc = (acc[0] && !match[0]) || (acc[1] && !match[1]) || (acc[2] && !match[2]);
    end

    assign miss0_retry = miss0_valid && !acc[0];
    assign miss1_retry = miss1_valid && !acc[1];
    assign miss2_retry = miss2_valid && !acc[2];

    // Round-robin pick starting after the last issued id; the entry sitting in
    // the request register is still PEND and must not be picked twice.
    always_comb begin
        can_load   = !req_valid_q || !l1tlbtol2tlb_req_retry;
        pick_found = 1'b0;
        pick_id    = 2'd0;
        idx        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!pick_found && ent_q[idx] == E_PEND && !(req_valid_q && req_id_q == idx)) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ent_q[i] <= E_IDLE;
                vpn_q[i] <= '0;
            end
            rr_ptr        <= 2'd0;
            req_valid_q   <= 1'b0;
            req_vpn_q     <= '0;
            req_id_q      <= 2'd0;
            fill_valid_q  <= 1'b0;
            fill_vpn_q    <= '0;
            fill_hpaddr_q <= '0;
            err_ack_q     <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            if (do_alloc) begin
                ent_q[alloc_id] <= E_PEND;
                vpn_q[alloc_id] <= alloc_vpn;
            end
            if (req_valid_q && !l1tlbtol2tlb_req_retry) ent_q[req_id_q] <= E_WAIT;
            if (l2tlbtol1tlb_ack_valid) begin
                if (ent_q[l2tlbtol1tlb_ack_id] == E_WAIT) begin
                    ent_q[l2tlbtol1tlb_ack_id] <= E_IDLE;
                    fill_valid_q  <= 1'b1;
                    fill_vpn_q    <= vpn_q[l2tlbtol1tlb_ack_id];
                    fill_hpaddr_q <= l2tlbtol1tlb_ack_hpaddr;
                end else begin
                    err_ack_q <= 1'b1;
                end
            end
            if (can_load) begin
                req_valid_q <= pick_found;
                if (pick_found) begin
                    req_vpn_q <= vpn_q[pick_id];
                    req_id_q  <= pick_id;
                    rr_ptr    <= pick_id;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snp_state  <= S_IDLE;
            snp_hpaddr <= '0;
        end else begin
            snp_state <= snp_next;
            if (snp_state == S_IDLE && l2tlbtol1tlb_snoop_valid) snp_hpaddr <= l2tlbtol1tlb_snoop_hpaddr;
        end
    end

    always_comb begin
        snp_next                 = snp_state;
        inv_valid                = 1'b0;
        l1tlbtol2tlb_sack_valid  = 1'b0;
        l2tlbtol1tlb_snoop_retry = 1'b1;
        case (snp_state)
            S_IDLE: begin
                l2tlbtol1tlb_snoop_retry = 1'b0;
                if (l2tlbtol1tlb_snoop_valid) snp_next = S_INV;
            end
            S_INV: begin
                inv_valid = 1'b1;
                if (!inv_retry) snp_next = S_SACK;
            end
            S_SACK: begin
                l1tlbtol2tlb_sack_valid = 1'b1;
                if (!l1tlbtol2tlb_sack_retry) snp_next = S_IDLE;
            end
            default: snp_next = S_IDLE;
        endcase
    end

    assign l1tlbtol2tlb_req_valid   = req_valid_q;
    assign l1tlbtol2tlb_req_vpn     = req_vpn_q;
    assign l1tlbtol2tlb_req_id      = req_id_q;
    assign l2tlbtol1tlb_ack_retry   = 1'b0;
    assign fill_valid               = fill_valid_q;
    assign fill_vpn                 = fill_vpn_q;
    assign fill_hpaddr              = fill_hpaddr_q;
    assign inv_hpaddr               = snp_hpaddr;
    assign l1tlbtol2tlb_sack_hpaddr = snp_hpaddr;
    assign err_ack                  = err_ack_q;
    assign dbg_snoop_state          = snp_state;
    assign dbg_entry_state          = {ent_q[3], ent_q[2], ent_q[1], ent_q[0]};

endmodule

// File: doc/dctlb_l2req_sched.md
DCTLB_L2REQ_SCHED -- requirements
Module: dctlb_l2req_sched

Interface
REQ-001 SHALL have parameter VPN_W, default 24, meaning virtual page number width.
REQ-002 SHALL have parameter HPA_W, default 12, meaning hpaddr width, the L2TLB entry handle.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports miss0_valid/miss0_retry/miss0_vpn, in/out/in, 1/1/VPN_W, the load-miss request.
REQ-006 SHALL have ports miss1_valid/miss1_retry/miss1_vpn, in/out/in, 1/1/VPN_W, the store-miss request.
REQ-007 SHALL have ports miss2_valid/miss2_retry/miss2_vpn, in/out/in, 1/1/VPN_W, the prefetch-miss request.
REQ-008 SHALL have ports l1tlbtol2tlb_req_valid/_retry/_vpn/_id, out/in/out/out, 1/1/VPN_W/2, the L2TLB request.
REQ-009 SHALL have ports l2tlbtol1tlb_ack_valid/_retry/_id/_hpaddr, in/out/in/in, 1/1/2/HPA_W, the L2TLB reply.
REQ-010 SHALL have ports fill_valid/fill_vpn/fill_hpaddr, out, 1/VPN_W/HPA_W, the TLB array fill.
REQ-011 SHALL have ports l2tlbtol1tlb_snoop_valid/_retry/_hpaddr, in/out/in, 1/1/HPA_W, the L2TLB displacement snoop.
REQ-012 SHALL have ports inv_valid/inv_retry/inv_hpaddr, out/in/out, 1/1/HPA_W, the invalidate to the TLB array and L1.
REQ-013 SHALL have ports l1tlbtol2tlb_sack_valid/_retry/_hpaddr, out/in/out, 1/1/HPA_W, the snoop acknowledge.
REQ-014 SHALL have port err_ack, output, 1, sticky flag for an ack to a non-waiting id.

Function
REQ-015 SHALL hold 4 miss entries (id 0-3), each in state IDLE, PEND (not yet issued) or WAIT (issued, awaiting ack), storing the vpn.
REQ-016 SHALL accept at most one miss per cycle with fixed priority miss0 > miss1 > miss2; the request accepted is the highest-priority valid one.
REQ-017 SHALL drive missN_retry combinationally as missN_valid AND NOT accepted.
REQ-018 SHALL merge a miss whose vpn equals that of any non-IDLE entry: accepted, no retry, no allocation.
REQ-019 SHALL allocate the lowest-index IDLE entry to PEND for an accepted non-merged miss; with no IDLE entry the miss is not accepted.
REQ-020 SHALL accept miss2 only when at least 2 entries are IDLE; merges are exempt.
REQ-021 SHALL not reallocate an entry freed by an ack before the cycle after the ack.
REQ-022 SHALL issue PEND entries round-robin, searching from the entry after the last issued id; req_valid/vpn/id SHALL be registered.
REQ-023 SHALL hold req_vpn/req_id stable while req_valid=1 and req_retry=1; on req_valid=1 and req_retry=0 the entry moves to WAIT.
REQ-024 SHALL tie l2tlbtol1tlb_ack_retry to 0.
REQ-025 SHALL, on an ack to an entry in WAIT, pulse fill_valid for 1 cycle on the next cycle with the entry vpn and ack hpaddr, and set the entry IDLE.
REQ-026 SHALL, on an ack to an entry not in WAIT, drop it and set err_ack=1 until reset.
REQ-027 SHALL run snoop FSM S_IDLE -> S_INV -> S_SACK -> S_IDLE.
REQ-028 SHALL leave S_IDLE on snoop_valid, capturing hpaddr.
REQ-029 SHALL hold inv_valid=1 in S_INV and leave on inv_retry=0.
REQ-030 SHALL hold sack_valid=1 in S_SACK and leave on sack_retry=0.
REQ-031 SHALL drive snoop_retry=1 in any snoop state other than S_IDLE.
REQ-032 SHALL keep a fill and a snoop in the same cycle independent: the fill is emitted and the invalidate follows at least 1 cycle later.
REQ-033 SHALL keep miss, issue, ack and snoop paths concurrent; none stalls another.

Reset
REQ-034 SHALL, on reset asserted, immediately set all entries IDLE, snoop FSM to S_IDLE, round-robin pointer to 0 and err_ack to 0.
REQ-035 SHALL drive every valid output and err_ack to 0 during reset and drive all data outputs to 0.
REQ-036 SHALL abandon any in-flight request on reset mid-operation; a later ack for it SHALL set err_ack.

Verification
REQ-037 SHALL cover: miss0 and miss1 valid together, vpn 0x10/0x20 -> miss0 accepted, miss1_retry=1; next cycle miss1 accepted; req ids 0 then 1.
REQ-038 SHALL cover: miss0 vpn 0x55 then miss1 vpn 0x55 -> one request only; ack id0 hpaddr 0x3A -> one fill_valid pulse, vpn 0x55, hpaddr 0x3A.
REQ-039 SHALL cover: 3 entries busy, miss2 valid -> miss2_retry=1; miss0 valid -> allocates id 3; fifth miss -> retry until an ack, then accepted a cycle after.
REQ-040 SHALL cover: req_retry held 5 cycles -> req_vpn/id stable throughout; entry stays PEND.
REQ-041 SHALL cover: snoop hpaddr 0x7F with inv_retry=1 for 2 cycles -> snoop_retry=1 throughout, inv_hpaddr=0x7F, then sack_valid with 0x7F, return to S_IDLE.
REQ-042 SHALL cover: ack id2 while entry 2 IDLE -> no fill, err_ack=1; reset -> err_ack=0.
